// File: rtl/sha512_pkg.sv
// Shared SHA-512 definitions: word width, round count, controller states,
// the K round-constant table, rotate helper and h_in/h_out slice offsets.
package sha512_pkg;

   localparam int WORD_W     = 64;
   localparam int ROUNDS_MAX = 80;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   // Low bit of each working word inside the packed 512-bit state (a is the MSW)
   localparam int A_LO = 448;
   localparam int B_LO = 384;
   localparam int C_LO = 320;
   localparam int D_LO = 256;
   localparam int E_LO = 192;
   localparam int F_LO = 128;
   localparam int G_LO = 64;
   localparam int H_LO = 0;

   localparam logic [63:0] K [0:79] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   // Rotate right by a constant amount (1..63)
   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      ror = (x >> n) | (x << (64 - n));
   endfunction

endpackage

// File: rtl/sha512_k_rom.sv
// K[t] round-constant lookup, purely combinational.
module sha512_k_rom
   import sha512_pkg::*;
(
   input  logic [6:0]  idx,
   output logic [63:0] k
);

   // Table read; indices past the last round read as zero
   always_comb begin
      k = '0;
      if (idx < 7'(ROUNDS_MAX)) k = K[idx];
   end

endmodule

// File: rtl/sha512_round_ctrl.sv
// SHA-512 compression sequencer: one round per accepted W[t] word.
// Optional feed-forward add of the chaining value: define SHA512_FEEDFORWARD_EN.
module sha512_round_ctrl
   import sha512_pkg::*;
#(
   parameter int ROUNDS = 80,
   parameter int WORD_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [8*WORD_W-1:0] h_in,
   input  logic                w_valid,
   input  logic [WORD_W-1:0]   w_data,
   output logic                w_ready,
   output logic                busy,
   output logic                done,
   output logic [8*WORD_W-1:0] h_out,
   output logic [6:0]          round_idx
);

   state_t st;
   logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
   logic [WORD_W-1:0] k_t, s0, s1, ch, maj, t1, t2;
   logic              last;
`ifdef SHA512_FEEDFORWARD_EN
   logic [8*WORD_W-1:0] h_save;
`endif

   sha512_k_rom u_k_rom (
      .idx (round_idx),
      .k   (k_t)
   );

   // Round function for the word currently on w_data
   always_comb begin
      s0   = ror(a, 28) ^ ror(a, 34) ^ ror(a, 39);
      s1   = ror(e, 14) ^ ror(e, 18) ^ ror(e, 41);
      ch   = (e & f) ^ (~e & g);
      maj  = (a & b) ^ (a & c) ^ (b & c);
      t1   = h + s1 + ch + k_t + w_data;
      t2   = s0 + maj;
      last = (round_idx == 7'(ROUNDS - 1));
   end

   // Block sequencer with registered handshake/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         w_ready   <= 1'b0;
         round_idx <= '0;
         h_out     <= '0;
         {a, b, c, d, e, f, g, h} <= '0;
`ifdef SHA512_FEEDFORWARD_EN
         h_save    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  a <= h_in[A_LO +: 64];
                  b <= h_in[B_LO +: 64];
                  c <= h_in[C_LO +: 64];
                  d <= h_in[D_LO +: 64];
                  e <= h_in[E_LO +: 64];
                  f <= h_in[F_LO +: 64];
                  g <= h_in[G_LO +: 64];
                  h <= h_in[H_LO +: 64];
`ifdef SHA512_FEEDFORWARD_EN
                  h_save <= h_in;
`endif
                  round_idx <= '0;
                  busy      <= 1'b1;
                  w_ready   <= 1'b1;
                  st        <= ROUND;
               end
            end
            ROUND: begin
               // Without w_valid nothing moves: a stall is simply a held cycle
               if (w_valid) begin
                  h <= g;
                  g <= f;
                  f <= e;
                  e <= d + t1;
                  d <= c;
                  c <= b;
                  b <= a;
                  a <= t1 + t2;
                  if (last) begin
                     round_idx <= '0;
                     w_ready   <= 1'b0;
                     st        <= FINAL;
                  end else begin
                     round_idx <= round_idx + 7'd1;
                  end
               end
            end
            FINAL: begin
`ifdef SHA512_FEEDFORWARD_EN
               h_out <= {a + h_save[A_LO +: 64], b + h_save[B_LO +: 64],
                         c + h_save[C_LO +: 64], d + h_save[D_LO +: 64],
                         e + h_save[E_LO +: 64], f + h_save[F_LO +: 64],
                         g + h_save[G_LO +: 64], h + h_save[H_LO +: 64]};
`else
               h_out <= {a, b, c, d, e, f, g, h};
`endif
               busy <= 1'b0;
               done <= 1'b1;
               st   <= DONE;
            end
            DONE: begin
               // start is deliberately not looked at here
               st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
